// File: rtl/hex_display_scheduler_if.sv
// hex_display_scheduler_if: PIO/hardware request inputs and display outputs of the hex display scheduler
interface hex_display_scheduler_if;
  logic [15:0] pio_digits;
  logic [15:0] hw_digits;
  logic hw_req;
  logic hw_blink;
  logic lz_blank;
  logic hw_ack;
  logic busy;
  logic src;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  modport master(
    output pio_digits, hw_req, hw_digits, hw_blink, lz_blank,
    input hw_ack, busy, src, hex0, hex1, hex2, hex3
  );
  modport slave(
    input pio_digits, hw_req, hw_digits, hw_blink, lz_blank,
    output hw_ack, busy, src, hex0, hex1, hex2, hex3
  );
endinterface

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: shares four hex displays between the PIO value and timed, optionally blinking hardware requests
module hex_display_scheduler #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int BLINK_HALF = 12500000
) (
  input logic clk,
  input logic rst,
  hex_display_scheduler_if.slave bus
);
  localparam int TW = $clog2(HOLD_CYCLES);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {S_PIO, S_HW} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [BW-1:0] cnt, cnt_nx;
  logic phase, phase_nx;
  logic [15:0] val, val_nx;
  logic blink, blink_nx;
  logic ack_nx;
  logic wrap;
  logic [15:0] sel;
  logic off;
  logic [3:0] blank;
  logic [6:0] seg_nx [4];
  assign wrap = cnt == BW'(BLINK_HALF - 1);
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    cnt_nx = cnt;
    phase_nx = phase;
    val_nx = val;
    blink_nx = blink;
    ack_nx = 1'b0;
    if (bus.hw_req) begin
      state_nx = S_HW;
      timer_nx = TW'(HOLD_CYCLES - 1);
      cnt_nx = '0;
      phase_nx = 1'b1;
      val_nx = bus.hw_digits;
      blink_nx = bus.hw_blink;
      ack_nx = 1'b1;
    end else if (state == S_HW) begin
      state_nx = timer == '0 ? S_PIO : S_HW;
      timer_nx = timer == '0 ? timer : timer - 1'b1;
      cnt_nx = blink ? (wrap ? '0 : cnt + 1'b1) : cnt;
      phase_nx = blink && wrap ? ~phase : phase;
    end
  end
  // blanking and blink are applied to whichever source currently owns the displays
  assign sel = state == S_HW ? val : bus.pio_digits;
  assign off = state == S_HW && blink && !phase;
  assign blank = {
    bus.lz_blank && sel[15:12] == 4'd0,
    bus.lz_blank && sel[15:8] == 8'd0,
    bus.lz_blank && sel[15:4] == 12'd0,
    1'b0
  };
  for (genvar i = 0; i < 4; i++) begin : g_dig
    assign seg_nx[i] = off || blank[i] ? 7'h7F : SEG[sel[4*i +: 4]];
  end
  assign bus.busy = state == S_HW;
  assign bus.src = state == S_HW;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_PIO;
      timer <= '0;
      cnt <= '0;
      phase <= 1'b1;
      val <= '0;
      blink <= 1'b0;
      bus.hw_ack <= 1'b0;
      bus.hex0 <= 7'h7F;
      bus.hex1 <= 7'h7F;
      bus.hex2 <= 7'h7F;
      bus.hex3 <= 7'h7F;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      cnt <= cnt_nx;
      phase <= phase_nx;
      val <= val_nx;
      blink <= blink_nx;
      bus.hw_ack <= ack_nx;
      bus.hex0 <= seg_nx[0];
      bus.hex1 <= seg_nx[1];
      bus.hex2 <= seg_nx[2];
      bus.hex3 <= seg_nx[3];
    end
  end
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: table vectors, corner sequences and random traffic against a cycle-count reference model
module tb_hex_display_scheduler;
  localparam int H = 10;
  localparam int B = 3;
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct {
    logic [15:0] pio;
    logic lz;
    logic [27:0] hx;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n = 0;
  int last_req = -1000;
  logic [15:0] m_val = '0;
  logic m_blink = 1'b0;
  logic e_ack, e_busy;
  logic [27:0] e_hex;
  vec_t tbl [9];
  always #5 clk = ~clk;
  hex_display_scheduler_if bus();
  hex_display_scheduler #(.HOLD_CYCLES(H), .BLINK_HALF(B)) dut(.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [27:0] disp(input logic [15:0] v, input logic lz, input logic off);
    logic [27:0] r;
    logic [3:0] d;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      d = v[4*k +: 4];
      r[7*k +: 7] = (off || (lz && k > 0 && (v >> (4*k)) == 16'd0)) ? 7'h7F : SEG[d];
    end
    return r;
  endfunction
  function automatic logic [27:0] hexes();
    return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask
  // the displays belong to hardware for H cycles after the last accepted request;
  // within that window the blink phase is off in every odd block of B cycles
  task automatic model();
    int k;
    logic hw, off;
    n++;
    if (rst) begin
      last_req = -1000;
      e_ack = 1'b0;
      e_busy = 1'b0;
      e_hex = '1;
      return;
    end
    k = n - 1 - last_req;
    hw = k < H;
    off = hw && m_blink && ((k / B) % 2 == 1);
    e_hex = disp(hw ? m_val : bus.pio_digits, bus.lz_blank, off);
    e_ack = bus.hw_req;
    if (bus.hw_req) begin
      last_req = n;
      m_val = bus.hw_digits;
      m_blink = bus.hw_blink;
    end
    e_busy = (n - last_req) < H;
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("ack", 32'(bus.hw_ack), 32'(e_ack));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("src", 32'(bus.src), 32'(e_busy));
    chk("hex", 32'(hexes()), 32'(e_hex));
  endtask
  task automatic drive(input logic req, input logic [15:0] d, input logic bl);
    bus.hw_req = req;
    bus.hw_digits = d;
    bus.hw_blink = bl;
  endtask
  task automatic idle(input int cycles);
    drive(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < cycles; i++) step();
  endtask
  initial begin
    int busy_cnt, ack_cnt;
    logic [27:0] v_beef, v_pio;
    tbl[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{16'h0007, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    tbl[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[3] = '{16'h0100, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}};
    tbl[4] = '{16'hBEEF, 1'b0, {7'h03, 7'h06, 7'h06, 7'h0E}};
    tbl[5] = '{16'h0042, 1'b0, {7'h40, 7'h40, 7'h19, 7'h24}};
    tbl[6] = '{16'h89AC, 1'b1, {7'h00, 7'h10, 7'h08, 7'h46}};
    tbl[7] = '{16'h0F00, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}};
    tbl[8] = '{16'h5601, 1'b0, {7'h12, 7'h02, 7'h40, 7'h79}};
    v_beef = tbl[4].hx;
    v_pio = tbl[0].hx;
    bus.pio_digits = 16'h1234;
    bus.lz_blank = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    step();
    step();
    chk("reset_hex", 32'(hexes()), 32'h0FFFFFFF);
    rst = 1'b0;
    step();
    step();
    chk("post_reset_hex", 32'(hexes()), 32'(v_pio));
    for (int i = 0; i < 9; i++) begin
      bus.pio_digits = tbl[i].pio;
      bus.lz_blank = tbl[i].lz;
      step();
      chk($sformatf("table%0d", i), 32'(hexes()), 32'(tbl[i].hx));
    end
    bus.pio_digits = 16'h1234;
    bus.lz_blank = 1'b0;
    idle(2);
    // single request: one ack, exactly H busy cycles
    drive(1'b1, 16'hBEEF, 1'b0);
    step();
    busy_cnt = int'(bus.busy);
    ack_cnt = int'(bus.hw_ack);
    drive(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      step();
      busy_cnt += int'(bus.busy);
      ack_cnt += int'(bus.hw_ack);
      if (i < 9) chk("beef_hex", 32'(hexes()), 32'(v_beef));
    end
    chk("single_busy_len", 32'(busy_cnt), 32'd10);
    chk("single_acks", 32'(ack_cnt), 32'd1);
    chk("single_back_to_pio", 32'(hexes()), 32'(v_pio));
    // retrigger on the 5th busy cycle extends the hold to 15 cycles
    drive(1'b1, 16'hBEEF, 1'b0);
    step();
    busy_cnt = int'(bus.busy);
    ack_cnt = int'(bus.hw_ack);
    drive(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      busy_cnt += int'(bus.busy);
      ack_cnt += int'(bus.hw_ack);
    end
    drive(1'b1, 16'h0042, 1'b0);
    step();
    busy_cnt += int'(bus.busy);
    ack_cnt += int'(bus.hw_ack);
    drive(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      step();
      busy_cnt += int'(bus.busy);
      ack_cnt += int'(bus.hw_ack);
      if (i == 0) chk("retrig_hex", 32'(hexes()), 32'(tbl[5].hx));
    end
    chk("retrig_busy_len", 32'(busy_cnt), 32'd15);
    chk("retrig_acks", 32'(ack_cnt), 32'd2);
    // blink: on x3, off x3, on x3, off x1, then PIO
    drive(1'b1, 16'hBEEF, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("blink%0d", i), 32'(hexes()),
          32'(i == 11 ? v_pio : (i inside {[4:6], 10}) ? 28'hFFFFFFF : v_beef));
    end
    // consecutive requests each ack
    drive(1'b1, 16'h0007, 1'b0);
    step();
    step();
    chk("back_to_back_ack", 32'(bus.hw_ack), 32'd1);
    idle(12);
    // reset on the 4th busy cycle discards the hold
    drive(1'b1, 16'hBEEF, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hex", 32'(hexes()), 32'h0FFFFFFF);
    rst = 1'b0;
    step();
    chk("rst_release_ack", 32'(bus.hw_ack), 32'd0);
    chk("rst_release_hex", 32'(hexes()), 32'(v_pio));
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      bus.pio_digits = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 300)) : 16'($urandom);
      bus.lz_blank = 1'($urandom);
      drive($urandom_range(0, 11) == 0, 16'($urandom), 1'($urandom));
      step();
    end
    rst = 1'b0;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
